// File: rtl/pc_ir_stack_unit.sv
// Control-unit sequencing datapath: IR, 9-bit PC with return-address load mux, {PC,flags} return stack.
// Registers update one clk edge after a strobe and outputs are combinational; PC_IR_STACK_GUARD_EN enables sticky overflow/underflow guards.
module pc_ir_stack_unit #(
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_load,
  input  logic [15:0] ir_in,
  output logic [15:0] ir_out,
  input  logic        pc_load,
  input  logic        pc_inc,
  input  logic        pc_en_out,
  output logic [8:0]  pc_out,
  output logic [8:0]  pc_bus,
  input  logic        push_en,
  input  logic        pop_en,
  input  logic [3:0]  flags_in,
  output logic [8:0]  stack_pc_out,
  output logic [3:0]  stack_flags_out,
  output logic        stack_empty,
  output logic        stack_full,
  output logic        stack_overflow,
  output logic        stack_underflow
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0]   FULL_DEPTH = (AW+1)'(STACK_DEPTH);
  localparam logic [AW:0]   DEPTH_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [4:0]    RET_OPCODE = 5'b10101;

  logic [15:0]   ir_q;
  logic [8:0]    pc_q;
  logic [8:0]    pc_load_val;
  logic [AW:0]   depth_q;
  logic [AW:0]   depth_d;
  logic [12:0]   stack_mem [STACK_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] top_ptr;
  logic [12:0]   top_entry;
  logic          do_push;
  logic          do_pop;
  logic          push_ok;
  logic          pop_ok;

  assign ir_out      = ir_q;
  assign pc_out      = pc_q;
  assign pc_bus      = pc_en_out ? pc_q : 9'd0;
  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == FULL_DEPTH);

  assign wr_ptr          = depth_q[AW-1:0];
  assign top_ptr         = depth_q[AW-1:0] - PTR_ONE;
  assign top_entry       = stack_empty ? 13'd0 : stack_mem[top_ptr];
  assign stack_pc_out    = top_entry[12:4];
  assign stack_flags_out = top_entry[3:0];

  // A return instruction reloads the PC from the entry being popped this cycle.
  assign pc_load_val = (ir_q[15:11] == RET_OPCODE) ? stack_pc_out : ir_q[10:2];

  assign do_push = push_en & ~pop_en;
  assign do_pop  = pop_en & ~push_en;

`ifdef PC_IR_STACK_GUARD_EN
  assign push_ok = do_push & ~stack_full;
`else
  // A push when full lands in slot 0 and the depth wraps to 0.
  assign push_ok = do_push;
`endif
  assign pop_ok = do_pop & ~stack_empty;

  always_comb begin
    depth_d = depth_q;
    if (push_ok) begin
      depth_d = stack_full ? '0 : depth_q + DEPTH_ONE;
    end else if (pop_ok) begin
      depth_d = depth_q - DEPTH_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[wr_ptr] <= {pc_q, flags_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q    <= 16'd0;
      pc_q    <= 9'd0;
      depth_q <= '0;
    end else begin
      if (ir_load) begin
        ir_q <= ir_in;
      end
      if (pc_load) begin
        pc_q <= pc_load_val;
      end else if (pc_inc) begin
        pc_q <= pc_q + 9'd1;
      end
      depth_q <= depth_d;
    end
  end

`ifdef PC_IR_STACK_GUARD_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (do_push && stack_full) begin
        ovf_q <= 1'b1;
      end
      if (do_pop && stack_empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
`else
  assign stack_overflow  = 1'b0;
  assign stack_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ir_stack_unit.sv
// Self-checking bench for pc_ir_stack_unit: directed vector table, corner sequences, randomized run vs. a queue model.
module tb_pc_ir_stack_unit;
  localparam int DEPTH = 8;
`ifdef PC_IR_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_load;
  logic [15:0] ir_in;
  logic [15:0] ir_out;
  logic        pc_load;
  logic        pc_inc;
  logic        pc_en_out;
  logic [8:0]  pc_out;
  logic [8:0]  pc_bus;
  logic        push_en;
  logic        pop_en;
  logic [3:0]  flags_in;
  logic [8:0]  stack_pc_out;
  logic [3:0]  stack_flags_out;
  logic        stack_empty;
  logic        stack_full;
  logic        stack_overflow;
  logic        stack_underflow;

  pc_ir_stack_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ir_load(ir_load), .ir_in(ir_in), .ir_out(ir_out),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_en_out(pc_en_out),
    .pc_out(pc_out), .pc_bus(pc_bus),
    .push_en(push_en), .pop_en(pop_en), .flags_in(flags_in),
    .stack_pc_out(stack_pc_out), .stack_flags_out(stack_flags_out),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model: plain registers plus a queue whose back is the top of stack.
  logic [15:0] m_ir;
  logic [8:0]  m_pc;
  logic [12:0] m_stk[$];
  logic        m_ovf;
  logic        m_unf;

  typedef struct {
    logic        il;
    logic [15:0] ii;
    logic        pl, pi, pe, pu, po;
    logic [3:0]  fl;
    logic [15:0] e_ir;
    logic [8:0]  e_pc, e_bus, e_tpc;
    logic [3:0]  e_tfl;
    logic        e_empty;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] m_top();
    if (m_stk.size() == 0) return 13'd0;
    return m_stk[m_stk.size()-1];
  endfunction

  task automatic model_reset();
    m_ir = 16'd0;
    m_pc = 9'd0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic il, input logic [15:0] ii, input logic pl, input logic pi,
                            input logic pu, input logic po, input logic [3:0] fl);
    logic [12:0] top;
    logic [8:0]  ld;
    logic [8:0]  old_pc;
    top    = m_top();
    ld     = (m_ir[15:11] == 5'b10101) ? top[12:4] : m_ir[10:2];
    old_pc = m_pc;
    if (pl) m_pc = ld;
    else if (pi) m_pc = 9'((int'(m_pc) + 1) % 512);
    if (pu && !po) begin
      if (m_stk.size() < DEPTH) m_stk.push_back({old_pc, fl});
      else if (GUARD) m_ovf = 1'b1;
      else m_stk.delete();
    end else if (po && !pu) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else if (GUARD) m_unf = 1'b1;
    end
    if (il) m_ir = ii;
  endtask

  task automatic compare_model();
    logic [12:0] top;
    top = m_top();
    check("ir_out", ir_out, m_ir);
    check("pc_out", pc_out, m_pc);
    check("pc_bus", pc_bus, pc_en_out ? m_pc : 9'd0);
    check("stack_pc_out", stack_pc_out, top[12:4]);
    check("stack_flags_out", stack_flags_out, top[3:0]);
    check("stack_empty", stack_empty, m_stk.size() == 0);
    check("stack_full", stack_full, m_stk.size() == DEPTH);
    check("stack_overflow", stack_overflow, m_ovf);
    check("stack_underflow", stack_underflow, m_unf);
  endtask

  task automatic cycle(input logic il, input logic [15:0] ii, input logic pl, input logic pi,
                       input logic pe, input logic pu, input logic po, input logic [3:0] fl);
    ir_load = il; ir_in = ii; pc_load = pl; pc_inc = pi;
    pc_en_out = pe; push_en = pu; pop_en = po; flags_in = fl;
    @(posedge clk);
    model_step(il, ii, pl, pi, pu, po, fl);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ir_load = 0; ir_in = 0; pc_load = 0; pc_inc = 0;
    pc_en_out = 0; push_en = 0; pop_en = 0; flags_in = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic        il, pl, pi, pe, pu, po;
    logic [15:0] ii;
    logic [3:0]  fl;
    int          push_w;

    n_cmp = 0;
    n_bad = 0;

    // Reset with strobes active: nothing may be captured.
    rst = 1'b1;
    ir_load = 1; ir_in = 16'hA5C3; pc_load = 0; pc_inc = 1;
    pc_en_out = 1; push_en = 1; pop_en = 0; flags_in = 4'hF;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_ir", ir_out, 16'd0);
    check("rst_pc", pc_out, 9'd0);
    check("rst_bus", pc_bus, 9'd0);
    check("rst_stack_pc", stack_pc_out, 9'd0);
    check("rst_stack_flags", stack_flags_out, 4'd0);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_full", stack_full, 1'b0);
    check("rst_ovf", stack_overflow, 1'b0);
    check("rst_unf", stack_underflow, 1'b0);
    rst = 1'b0;

    //           il    ii        pl    pi    pe    pu    po    fl      e_ir      e_pc     e_bus    e_tpc   e_tfl  e_empty
    vecs[0]  = '{1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'hA5C3, 9'd0,   9'd0,   9'd0,  4'h0, 1'b1};
    vecs[1]  = '{1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'hA5C3, 9'd0,   9'd0,   9'd0,  4'h0, 1'b1};
    vecs[2]  = '{1'b1, 16'h07F8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h07F8, 9'd0,   9'd0,   9'd0,  4'h0, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h07F8, 9'd510, 9'd0,   9'd0,  4'h0, 1'b1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h07F8, 9'd511, 9'd511, 9'd0,  4'h0, 1'b1};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h07F8, 9'd0,   9'd0,   9'd0,  4'h0, 1'b1};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h07F8, 9'd1,   9'd0,   9'd0,  4'h0, 1'b1};
    vecs[7]  = '{1'b1, 16'h84B0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h84B0, 9'd1,   9'd0,   9'd0,  4'h0, 1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h84B0, 9'd300, 9'd0,   9'd0,  4'h0, 1'b1};
    vecs[9]  = '{1'b1, 16'h00A8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h00A8, 9'd300, 9'd0,   9'd0,  4'h0, 1'b1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h00A8, 9'd42,  9'd42,  9'd0,  4'h0, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 16'h00A8, 9'd42,  9'd0,   9'd42, 4'hA, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h00A8, 9'd43,  9'd0,   9'd42, 4'hA, 1'b0};
    vecs[13] = '{1'b1, 16'hA800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'hA800, 9'd43,  9'd0,   9'd42, 4'hA, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'hA800, 9'd42,  9'd0,   9'd0,  4'h0, 1'b1};

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].il, vecs[i].ii, vecs[i].pl, vecs[i].pi, vecs[i].pe, vecs[i].pu, vecs[i].po, vecs[i].fl);
      check($sformatf("vec%0d_ir", i), ir_out, vecs[i].e_ir);
      check($sformatf("vec%0d_pc", i), pc_out, vecs[i].e_pc);
      check($sformatf("vec%0d_bus", i), pc_bus, vecs[i].e_bus);
      check($sformatf("vec%0d_top_pc", i), stack_pc_out, vecs[i].e_tpc);
      check($sformatf("vec%0d_top_flags", i), stack_flags_out, vecs[i].e_tfl);
      check($sformatf("vec%0d_empty", i), stack_empty, vecs[i].e_empty);
    end

    // Fill to capacity with PCs 1..8, push once more, then pop nine times.
    do_reset();
    cycle(0, 16'h0, 0, 1, 0, 0, 0, 4'h0);
    for (int i = 1; i <= DEPTH; i++) cycle(0, 16'h0, 0, 1, 0, 1, 0, 4'(i));
    check("fill_full", stack_full, 1'b1);
    check("fill_top", stack_pc_out, 9'd8);
    check("fill_top_flags", stack_flags_out, 4'd8);
    cycle(0, 16'h0, 0, 1, 0, 1, 0, 4'h9);
    check("ovf_flag", stack_overflow, GUARD);
    check("ovf_top", stack_pc_out, GUARD ? 9'd8 : 9'd0);
    check("ovf_full", stack_full, GUARD);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("pop%0d_top", i), stack_pc_out, (GUARD && i < 8) ? 9'(8 - i) : 9'd0);
      cycle(0, 16'h0, 0, 0, 0, 0, 1, 4'h0);
    end
    check("unf_flag", stack_underflow, GUARD);
    check("unf_empty", stack_empty, 1'b1);

    // Simultaneous push and pop leaves the single entry untouched.
    do_reset();
    repeat (5) cycle(0, 16'h0, 0, 1, 0, 0, 0, 4'h0);
    cycle(0, 16'h0, 0, 0, 0, 1, 0, 4'h3);
    cycle(0, 16'h0, 0, 0, 0, 1, 1, 4'hC);
    check("pp_top_pc", stack_pc_out, 9'd5);
    check("pp_top_flags", stack_flags_out, 4'h3);
    check("pp_empty", stack_empty, 1'b0);
    cycle(0, 16'h0, 0, 0, 0, 0, 1, 4'h0);
    check("pp_depth1", stack_empty, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    cycle(1, 16'hBEEF, 0, 1, 1, 1, 0, 4'h7);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ir", ir_out, 16'd0);
    check("arst_pc", pc_out, 9'd0);
    check("arst_bus", pc_bus, 9'd0);
    check("arst_stack_pc", stack_pc_out, 9'd0);
    check("arst_stack_flags", stack_flags_out, 4'd0);
    check("arst_empty", stack_empty, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized run alternating push-heavy and pop-heavy phases.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        push_w = ((k / 200) % 2 == 0) ? 7 : 2;
        il = ($urandom_range(0, 2) == 0);
        ii = ($urandom_range(0, 3) == 0) ? {5'b10101, 11'($urandom)} : 16'($urandom);
        pl = ($urandom_range(0, 4) == 0);
        pi = 1'($urandom);
        pe = 1'($urandom);
        pu = ($urandom_range(0, 9) < push_w);
        po = ($urandom_range(0, 9) < 9 - push_w);
        fl = 4'($urandom);
        cycle(il, ii, pl, pi, pe, pu, po, fl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
